// File: rtl/vercompare_serial_if.sv
`timescale 1ns/1ps
// Request/response bundle between register-read, the serial branch comparator and PC-update logic.
interface vercompare_serial_if #(
    parameter int WIDTH = 32
);
  logic             req_vld;
  logic             req_rdy;
  logic             is_branch;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a_dat;
  logic [WIDTH-1:0] b_dat;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic             taken;
  logic             eq;
  logic             lt;
  logic             ltu;

  modport master (
    output req_vld, is_branch, funct3, a_dat, b_dat, rsp_rdy,
    input  req_rdy, rsp_vld, taken, eq, lt, ltu
  );

  modport slave (
    input  req_vld, is_branch, funct3, a_dat, b_dat, rsp_rdy,
    output req_rdy, rsp_vld, taken, eq, lt, ltu
  );
endinterface

// File: rtl/vercompare_serial.sv
`timescale 1ns/1ps
// Serial RV32I branch comparator, DIGIT bits per cycle LSB-first; result valid N=WIDTH/DIGIT cycles after accept.
// Non-overlapping: req_rdy only in IDLE; result held stable in DONE while rsp_rdy is low.
module vercompare_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
  input logic                 core_clk,
  input logic                 arst_n,
  vercompare_serial_if.slave  cmp_if
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic ltu;
  } res_t;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [2:0]       f3_q,      f3_d;
  logic             eq_acc_q,  eq_acc_d;
  logic             ltu_acc_q, ltu_acc_d;
  res_t             res_q,     res_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_ne, dig_ltu, dig_lts, last_dig;
  logic             fin_eq, fin_lt, fin_ltu;

  function automatic logic br_taken(input logic [2:0] f3, input logic e,
                                    input logic l, input logic lu);
    case (f3)
      3'b000:  return e;
      3'b001:  return !e;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  // Operands shift right each RUN cycle so the current digit always sits at bit 0.
  assign a_dig    = a_q[DIGIT-1:0];
  assign b_dig    = b_q[DIGIT-1:0];
  assign dig_ne   = (a_dig != b_dig);
  assign dig_ltu  = (a_dig < b_dig);
  assign dig_lts  = ($signed(a_dig) < $signed(b_dig));
  assign last_dig = (cnt_q == CW'(N - 1));

  assign fin_eq  = eq_acc_q & ~dig_ne;
  assign fin_ltu = dig_ne ? dig_ltu : ltu_acc_q;
  // Only the top digit carries the sign; lower digits always resolve unsigned.
  assign fin_lt  = dig_ne ? dig_lts : ltu_acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    eq_acc_d  = eq_acc_q;
    ltu_acc_d = ltu_acc_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: begin
        if (cmp_if.req_vld) begin
          a_d       = cmp_if.a_dat;
          b_d       = cmp_if.b_dat;
          f3_d      = cmp_if.funct3;
          eq_acc_d  = 1'b1;
          ltu_acc_d = 1'b0;
          cnt_d     = '0;
          if (cmp_if.is_branch) begin
            state_d = S_RUN;
          end else begin
            res_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        a_d       = a_q >> DIGIT;
        b_d       = b_q >> DIGIT;
        eq_acc_d  = fin_eq;
        ltu_acc_d = fin_ltu;
        if (last_dig) begin
          res_d.taken = br_taken(f3_q, fin_eq, fin_lt, fin_ltu);
          res_d.eq    = fin_eq;
          res_d.lt    = fin_lt;
          res_d.ltu   = fin_ltu;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (cmp_if.rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      eq_acc_q  <= 1'b1;
      ltu_acc_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      eq_acc_q  <= eq_acc_d;
      ltu_acc_q <= ltu_acc_d;
      res_q     <= res_d;
    end
  end

  assign cmp_if.req_rdy = (state_q == S_IDLE);
  assign cmp_if.rsp_vld = (state_q == S_DONE);
  assign cmp_if.taken   = res_q.taken;
  assign cmp_if.eq      = res_q.eq;
  assign cmp_if.lt      = res_q.lt;
  assign cmp_if.ltu     = res_q.ltu;
endmodule

// File: tb/tb_vercompare_serial.sv
`timescale 1ns/1ps
// Directed and reference-compared bench for the serial branch comparator.
module tb_vercompare_serial;
  logic core_clk = 1'b0;
  logic arst_n   = 1'b0;
  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;

  vercompare_serial_if #(.WIDTH(32)) m();
  vercompare_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .core_clk(core_clk), .arst_n(arst_n), .cmp_if(m));

  logic [3:0] m_res;
  assign m_res = {m.taken, m.eq, m.lt, m.ltu};

  // Sweep instances share one stimulus source.
  logic        sw_vld, sw_br, sw_rdy;
  logic [2:0]  sw_f3;
  logic [31:0] sw_a, sw_b;
  vercompare_serial_if #(.WIDTH(32)) i1();
  vercompare_serial_if #(.WIDTH(32)) i4();
  vercompare_serial_if #(.WIDTH(32)) i32();
  vercompare_serial #(.WIDTH(32), .DIGIT(1))  s1  (.core_clk(core_clk), .arst_n(arst_n), .cmp_if(i1));
  vercompare_serial #(.WIDTH(32), .DIGIT(4))  s4  (.core_clk(core_clk), .arst_n(arst_n), .cmp_if(i4));
  vercompare_serial #(.WIDTH(32), .DIGIT(32)) s32 (.core_clk(core_clk), .arst_n(arst_n), .cmp_if(i32));
  assign i1.req_vld  = sw_vld; assign i1.is_branch  = sw_br; assign i1.funct3  = sw_f3;
  assign i1.a_dat    = sw_a;   assign i1.b_dat      = sw_b;  assign i1.rsp_rdy = sw_rdy;
  assign i4.req_vld  = sw_vld; assign i4.is_branch  = sw_br; assign i4.funct3  = sw_f3;
  assign i4.a_dat    = sw_a;   assign i4.b_dat      = sw_b;  assign i4.rsp_rdy = sw_rdy;
  assign i32.req_vld = sw_vld; assign i32.is_branch = sw_br; assign i32.funct3 = sw_f3;
  assign i32.a_dat   = sw_a;   assign i32.b_dat     = sw_b;  assign i32.rsp_rdy = sw_rdy;

  function automatic logic [3:0] ref_cmp(input logic br, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    logic e, l, lu, t;
    if (!br) return 4'b0000;
    e  = (a == b);
    l  = ($signed(a) < $signed(b));
    lu = (a < b);
    case (f3)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100:  t = l;
      3'b101:  t = !l;
      3'b110:  t = lu;
      3'b111:  t = !lu;
      default: t = 1'b0;
    endcase
    return {t, e, l, lu};
  endfunction

  task automatic send(input logic br, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    m.req_vld = 1'b1; m.is_branch = br; m.funct3 = f3; m.a_dat = a; m.b_dat = b;
    while (!m.req_rdy && guard < 100) begin
      @(posedge core_clk); #1; guard++;
    end
    @(posedge core_clk); #1;
    m.req_vld = 1'b0; m.a_dat = '1; m.b_dat = '0; m.funct3 = 3'b010;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!m.rsp_vld && lat < 100) begin
      @(posedge core_clk); #1; lat++;
    end
  endtask

  task automatic run_txn(input logic br, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [3:0] res);
    send(br, f3, a, b);
    wait_rsp(lat);
    res = m_res;
    @(posedge core_clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge core_clk);
    #1;
    checks++;
    if ({m.req_rdy, m.rsp_vld, m_res} !== 6'b10_0000) begin
      errors++; $display("FAIL reset_hold rdy/vld/res=%b exp 100000", {m.req_rdy, m.rsp_vld, m_res});
    end
    arst_n = 1'b1;
    @(posedge core_clk); #1;
    checks++;
    if ({m.req_rdy, m.rsp_vld, m_res} !== 6'b10_0000) begin
      errors++; $display("FAIL reset_release rdy/vld/res=%b exp 100000", {m.req_rdy, m.rsp_vld, m_res});
    end
  endtask

  task automatic test_beq_bne();
    int lat; logic [3:0] res;
    run_txn(1'b1, 3'b000, 32'h12345678, 32'h12345678, lat, res);
    checks++;
    if (lat !== 4 || res !== 4'b1100) begin
      errors++; $display("FAIL beq lat=%0d res=%b exp lat=4 res=1100", lat, res);
    end
    run_txn(1'b1, 3'b001, 32'h12345678, 32'h12345678, lat, res);
    checks++;
    if (lat !== 4 || res !== 4'b0100) begin
      errors++; $display("FAIL bne lat=%0d res=%b exp lat=4 res=0100", lat, res);
    end
  endtask

  task automatic test_signed_unsigned();
    int lat; logic [3:0] res;
    logic [2:0]  f3s [3] = '{3'b100, 3'b110, 3'b111};
    logic [3:0]  exps[3] = '{4'b1010, 4'b0010, 4'b1010};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, f3s[i], 32'hFFFFFFFF, 32'h00000001, lat, res);
      checks++;
      if (lat !== 4 || res !== exps[i]) begin
        errors++; $display("FAIL neg_vs_one f3=%b lat=%0d res=%b exp lat=4 res=%b", f3s[i], lat, res, exps[i]);
      end
    end
  endtask

  task automatic test_low_digit();
    int lat; logic [3:0] res;
    logic [2:0]  f3s [5] = '{3'b110, 3'b100, 3'b101, 3'b101, 3'b111};
    logic [31:0] as  [5] = '{32'h7F000001, 32'h7F000001, 32'h7F000001, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [5] = '{32'h7F000002, 32'h7F000002, 32'h7F000002, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic [3:0]  exps[5] = '{4'b1011, 4'b1011, 4'b0011, 4'b0010, 4'b1010};
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b1, f3s[i], as[i], bs[i], lat, res);
      checks++;
      if (lat !== 4 || res !== exps[i]) begin
        errors++; $display("FAIL digit_case%0d lat=%0d res=%b exp lat=4 res=%b", i, lat, res, exps[i]);
      end
    end
  endtask

  task automatic test_non_branch();
    int lat; logic [3:0] res;
    run_txn(1'b0, 3'b000, 32'h5A5A5A5A, 32'h5A5A5A5A, lat, res);
    checks++;
    if (lat !== 0 || res !== 4'b0000) begin
      errors++; $display("FAIL non_branch lat=%0d res=%b exp lat=0 res=0000", lat, res);
    end
    run_txn(1'b1, 3'b010, 32'hCAFEBABE, 32'hCAFEBABE, lat, res);
    checks++;
    if (lat !== 4 || res !== 4'b0100) begin
      errors++; $display("FAIL f3_010 lat=%0d res=%b exp lat=4 res=0100", lat, res);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic bad;
    m.rsp_rdy = 1'b0;
    send(1'b1, 3'b100, 32'hFFFFFFFF, 32'h00000001);
    wait_rsp(lat);
    // A competing request is held while the result is stalled.
    m.req_vld = 1'b1; m.is_branch = 1'b1; m.funct3 = 3'b000;
    m.a_dat = 32'h0BADF00D; m.b_dat = 32'h0BADF00D;
    bad = (lat !== 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge core_clk); #1;
      if (m.rsp_vld !== 1'b1 || m.req_rdy !== 1'b0 || m_res !== 4'b1010) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_stall vld=%b rdy=%b res=%b exp vld=1 rdy=0 res=1010", m.rsp_vld, m.req_rdy, m_res);
    end
    m.rsp_rdy = 1'b1;
    @(posedge core_clk); #1;
    checks++;
    if (m.req_rdy !== 1'b1 || m.rsp_vld !== 1'b0) begin
      errors++; $display("FAIL bp_release rdy=%b vld=%b exp rdy=1 vld=0", m.req_rdy, m.rsp_vld);
    end
    @(posedge core_clk); #1;
    m.req_vld = 1'b0;
    checks++;
    if (m.req_rdy !== 1'b0) begin
      errors++; $display("FAIL bp_accept rdy=%b exp 0", m.req_rdy);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 4 || m_res !== 4'b1100) begin
      errors++; $display("FAIL bp_next lat=%0d res=%b exp lat=4 res=1100", lat, m_res);
    end
    @(posedge core_clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] res;
    m.req_vld = 1'b1; m.is_branch = 1'b0; m.funct3 = 3'b000;
    m.a_dat = 32'h1; m.b_dat = 32'h1;
    @(posedge core_clk); #1;
    checks++;
    if (m.rsp_vld !== 1'b1 || m.req_rdy !== 1'b0) begin
      errors++; $display("FAIL b2b_first vld=%b rdy=%b exp vld=1 rdy=0", m.rsp_vld, m.req_rdy);
    end
    @(posedge core_clk); #1;
    checks++;
    if (m.rsp_vld !== 1'b0 || m.req_rdy !== 1'b1) begin
      errors++; $display("FAIL b2b_gap vld=%b rdy=%b exp vld=0 rdy=1", m.rsp_vld, m.req_rdy);
    end
    @(posedge core_clk); #1;
    m.req_vld = 1'b0;
    checks++;
    if (m.rsp_vld !== 1'b1 || m.req_rdy !== 1'b0) begin
      errors++; $display("FAIL b2b_second vld=%b rdy=%b exp vld=1 rdy=0", m.rsp_vld, m.req_rdy);
    end
    @(posedge core_clk); #1;
    run_txn(1'b1, 3'b110, 32'h00000010, 32'h00000100, lat, res);
    run_txn(1'b1, 3'b111, 32'h00000010, 32'h00000100, lat, res);
    checks++;
    if (lat !== 4 || res !== 4'b0011) begin
      errors++; $display("FAIL b2b_branch lat=%0d res=%b exp lat=4 res=0011", lat, res);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [3:0] res; logic bad;
    run_txn(1'b1, 3'b000, 32'h00000042, 32'h00000042, lat, res);
    send(1'b1, 3'b001, 32'h00000001, 32'h00000002);
    repeat (2) begin @(posedge core_clk); #1; end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({m.req_rdy, m.rsp_vld, m_res} !== 6'b10_0000) begin
      errors++; $display("FAIL reset_mid_run rdy/vld/res=%b exp 100000", {m.req_rdy, m.rsp_vld, m_res});
    end
    @(posedge core_clk); #1;
    arst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge core_clk); #1;
      if (m.rsp_vld !== 1'b0 || m.req_rdy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_abort vld=%b rdy=%b exp vld=0 rdy=1", m.rsp_vld, m.req_rdy);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp;
    int guard, mode;
    for (int it = 0; it < 1000; it++) begin
      mode = $urandom_range(0, 3);
      sw_a = $urandom;
      case (mode)
        0:       sw_b = $urandom;
        1:       sw_b = sw_a;
        2:       sw_b = sw_a ^ (32'd1 << $urandom_range(0, 31));
        default: sw_b = {~sw_a[31], sw_a[30:0]};
      endcase
      sw_f3 = 3'($urandom_range(0, 7));
      sw_br = ($urandom_range(0, 15) != 0);
      exp   = ref_cmp(sw_br, sw_f3, sw_a, sw_b);
      sw_vld = 1'b1;
      @(posedge core_clk); #1;
      sw_vld = 1'b0;
      guard = 0;
      while (!(i1.rsp_vld && i4.rsp_vld && i32.rsp_vld) && guard < 64) begin
        @(posedge core_clk); #1; guard++;
      end
      checks++;
      if ({i1.rsp_vld, i1.taken, i1.eq, i1.lt, i1.ltu} !== {1'b1, exp}) begin
        errors++; $display("FAIL sweep_d1 a=%h b=%h f3=%b got %b exp %b", sw_a, sw_b, sw_f3,
                           {i1.rsp_vld, i1.taken, i1.eq, i1.lt, i1.ltu}, {1'b1, exp});
      end
      checks++;
      if ({i4.rsp_vld, i4.taken, i4.eq, i4.lt, i4.ltu} !== {1'b1, exp}) begin
        errors++; $display("FAIL sweep_d4 a=%h b=%h f3=%b got %b exp %b", sw_a, sw_b, sw_f3,
                           {i4.rsp_vld, i4.taken, i4.eq, i4.lt, i4.ltu}, {1'b1, exp});
      end
      checks++;
      if ({i32.rsp_vld, i32.taken, i32.eq, i32.lt, i32.ltu} !== {1'b1, exp}) begin
        errors++; $display("FAIL sweep_d32 a=%h b=%h f3=%b got %b exp %b", sw_a, sw_b, sw_f3,
                           {i32.rsp_vld, i32.taken, i32.eq, i32.lt, i32.ltu}, {1'b1, exp});
      end
      sw_rdy = 1'b1;
      @(posedge core_clk); #1;
      sw_rdy = 1'b0;
    end
  endtask

  initial begin
    m.req_vld = 1'b0; m.is_branch = 1'b0; m.funct3 = 3'b000;
    m.a_dat = '0; m.b_dat = '0; m.rsp_rdy = 1'b1;
    sw_vld = 1'b0; sw_br = 1'b0; sw_rdy = 1'b0; sw_f3 = 3'b000; sw_a = '0; sw_b = '0;
    test_reset();
    test_beq_bne();
    test_signed_unsigned();
    test_low_digit();
    test_non_branch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
